// File: rtl/eth_rgmii_speed_detect_pkg.sv
// Shared RGMII link-speed encodings and helpers used by the speed detector
// and its hysteresis filter.
package eth_rgmii_speed_detect_pkg;

    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10
    } speed_e;

    function automatic logic is_mii(input speed_e spd);
        return (spd != SPEED_1000M);
    endfunction

endpackage

// File: rtl/eth_speed_hyst_filter.sv
// Hysteresis filter: commits a speed after HYST_COUNT consecutive agreeing
// votes and drops validity on a link-loss timeout.
module eth_speed_hyst_filter
    import eth_rgmii_speed_detect_pkg::*;
#(
    parameter int HYST_COUNT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   vote_valid,
    input  speed_e vote,
    input  logic   timeout,
    output speed_e speed,
    output logic   mii_select,
    output logic   speed_valid,
    output logic   speed_change
);

    localparam int CNT_W = $clog2(HYST_COUNT + 1);
    localparam logic [CNT_W-1:0] HYST_CNT = CNT_W'(HYST_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    speed_e           cand_r;
    logic [CNT_W-1:0] cand_cnt_r;
    speed_e           speed_r;
    logic             mii_select_r;
    logic             speed_valid_r;
    logic             speed_change_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             commit_s;

    // Candidate count after this vote; a disagreeing vote restarts the run at one
    always_comb begin
        cnt_next_s = cand_cnt_r;
        commit_s   = 1'b0;
        if (vote == cand_r) begin
            if (cand_cnt_r >= HYST_CNT) begin
                cnt_next_s = HYST_CNT;
            end else begin
                cnt_next_s = cand_cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = CNT_ONE;
        end
        if (vote_valid && (cnt_next_s >= HYST_CNT) && ((vote != speed_r) || !speed_valid_r)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Candidate tracking, commit and timeout; a timeout leaves speed untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_r         <= SPEED_10M;
            cand_cnt_r     <= {CNT_W{1'b0}};
            speed_r        <= SPEED_1000M;
            mii_select_r   <= 1'b0;
            speed_valid_r  <= 1'b0;
            speed_change_r <= 1'b0;
        end else begin
            speed_change_r <= 1'b0;
            if (vote_valid) begin
                cand_r     <= vote;
                cand_cnt_r <= cnt_next_s;
                if (commit_s) begin
                    speed_r        <= vote;
                    mii_select_r   <= is_mii(vote);
                    speed_valid_r  <= 1'b1;
                    speed_change_r <= 1'b1;
                end
            end else if (timeout && speed_valid_r) begin
                speed_valid_r  <= 1'b0;
                cand_cnt_r     <= {CNT_W{1'b0}};
                speed_change_r <= 1'b1;
            end
        end
    end

    assign speed        = speed_r;
    assign mii_select   = mii_select_r;
    assign speed_valid  = speed_valid_r;
    assign speed_change = speed_change_r;

endmodule

// File: rtl/eth_rgmii_speed_detect.sv
// RGMII link-speed detector: counts prescaled rx-clock edges per reference
// window, votes 10/100/1000M and commits through a hysteresis filter.
module eth_rgmii_speed_detect
    import eth_rgmii_speed_detect_pkg::*;
#(
    parameter int REF_CNT_W    = 7,
    parameter int EDGE_CNT_W   = 2,
    parameter int THRESH_100   = 32,
    parameter int HYST_COUNT   = 2,
    parameter int LINK_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prescale_toggle,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       speed_valid,
    output logic       speed_change
);

    localparam int ZERO_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [REF_CNT_W-1:0] THRESH    = REF_CNT_W'(THRESH_100);
    localparam logic [ZERO_W-1:0]    ZERO_MAX  = ZERO_W'(LINK_TIMEOUT);
    localparam logic [ZERO_W-1:0]    ZERO_LAST = ZERO_W'(LINK_TIMEOUT - 1);

    logic                  toggle_q_r;
    logic                  edge_r;
    logic [REF_CNT_W-1:0]  ref_cnt_r;
    logic [EDGE_CNT_W-1:0] edge_cnt_r;
    logic [ZERO_W-1:0]     zero_cnt_r;
    logic                  vote_valid_s;
    speed_e                vote_s;
    logic                  zero_win_s;
    logic                  win_end_s;
    logic                  timeout_s;
    speed_e                speed_s;

    // Window-end classification; edge saturation takes priority over ref expiry
    always_comb begin
        vote_valid_s = 1'b0;
        vote_s       = SPEED_10M;
        zero_win_s   = 1'b0;
        if (&edge_cnt_r) begin
            vote_valid_s = 1'b1;
            vote_s       = (ref_cnt_r < THRESH) ? SPEED_1000M : SPEED_100M;
        end else if (&ref_cnt_r) begin
            if (edge_cnt_r != {EDGE_CNT_W{1'b0}}) begin
                vote_valid_s = 1'b1;
                vote_s       = SPEED_10M;
            end else begin
                zero_win_s = 1'b1;
            end
        end else begin
            vote_valid_s = 1'b0;
        end
    end

    assign win_end_s = (&edge_cnt_r) || (&ref_cnt_r);
    assign timeout_s = zero_win_s && (zero_cnt_r >= ZERO_LAST);

    // Edge detect, window counters and zero-edge window count
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q_r <= prescale_toggle;
            edge_r     <= 1'b0;
            ref_cnt_r  <= {REF_CNT_W{1'b0}};
            edge_cnt_r <= {EDGE_CNT_W{1'b0}};
            zero_cnt_r <= {ZERO_W{1'b0}};
        end else begin
            toggle_q_r <= prescale_toggle;
            edge_r     <= prescale_toggle ^ toggle_q_r;
            if (win_end_s) begin
                ref_cnt_r  <= {REF_CNT_W{1'b0}};
                edge_cnt_r <= {EDGE_CNT_W{1'b0}};
            end else begin
                ref_cnt_r <= ref_cnt_r + 1'b1;
                if (edge_r) begin
                    edge_cnt_r <= edge_cnt_r + 1'b1;
                end
            end
            if (vote_valid_s) begin
                zero_cnt_r <= {ZERO_W{1'b0}};
            end else if (zero_win_s && (zero_cnt_r < ZERO_MAX)) begin
                zero_cnt_r <= zero_cnt_r + 1'b1;
            end
        end
    end

    eth_speed_hyst_filter #(
        .HYST_COUNT (HYST_COUNT)
    ) u_hyst (
        .clk          (clk),
        .rst          (rst),
        .vote_valid   (vote_valid_s),
        .vote         (vote_s),
        .timeout      (timeout_s),
        .speed        (speed_s),
        .mii_select   (mii_select),
        .speed_valid  (speed_valid),
        .speed_change (speed_change)
    );

    assign speed = speed_s;

endmodule

// File: tb/tb_eth_rgmii_speed_detect.sv
// Directed bench for eth_rgmii_speed_detect: expected speed_change events are
// queued per phase and matched against pulses captured by a monitor.
module tb_eth_rgmii_speed_detect;

    typedef struct packed {
        logic [1:0] spd;
        logic       mii;
        logic       vld;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prescale_toggle = 1'b0;
    logic [1:0] speed;
    logic       mii_select;
    logic       speed_valid;
    logic       speed_change;

    int  vectors = 0;
    int  miscompares = 0;
    int  tog_per = 0;
    int  ph = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    eth_rgmii_speed_detect dut (
        .clk             (clk),
        .rst             (rst),
        .prescale_toggle (prescale_toggle),
        .speed           (speed),
        .mii_select      (mii_select),
        .speed_valid     (speed_valid),
        .speed_change    (speed_change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (speed_change === 1'b1) begin
            obs_q.push_back({speed, mii_select, speed_valid});
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] spd, input logic mii, input logic vld);
        check({tag, "_speed"}, 8'(speed), 8'(spd));
        check({tag, "_mii"}, 8'(mii_select), 8'(mii));
        check({tag, "_valid"}, 8'(speed_valid), 8'(vld));
    endtask

    task automatic check_events(input string tag);
        check({tag, "_events"}, 8'(obs_q.size()), 8'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_event"}, 8'(o), 8'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tog_per != 0) begin
                ph++;
                if (ph >= tog_per) begin
                    ph = 0;
                    prescale_toggle = ~prescale_toggle;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        run(3);
        check_state("reset", 2'b10, 1'b0, 1'b0);
        check("reset_change", 8'(speed_change), 8'h00);

        // 1000M lock: no commit after one window, one pulse after two
        rst = 1'b0;
        tog_per = 4;
        ph = 0;
        run(20);
        check("g_hyst_valid", 8'(speed_valid), 8'h00);
        exp_q.push_back({2'b10, 1'b0, 1'b1});
        run(40);
        check_state("g_lock", 2'b10, 1'b0, 1'b1);
        check_events("g_lock");

        // 100M lock
        tog_per = 40;
        exp_q.push_back({2'b01, 1'b1, 1'b1});
        run(600);
        check_state("f_lock", 2'b01, 1'b1, 1'b1);
        check_events("f_lock");

        // 10M lock; zero-edge gaps must not drop validity
        tog_per = 200;
        exp_q.push_back({2'b00, 1'b1, 1'b1});
        run(1500);
        check_state("t_lock", 2'b00, 1'b1, 1'b1);
        check_events("t_lock");

        // Back to 1000M
        tog_per = 4;
        exp_q.push_back({2'b10, 1'b0, 1'b1});
        run(200);
        check_state("g_relock", 2'b10, 1'b0, 1'b1);
        check_events("g_relock");

        // Link loss after four zero-edge windows
        tog_per = 0;
        run(300);
        check("loss_early_valid", 8'(speed_valid), 8'h01);
        exp_q.push_back({2'b10, 1'b0, 1'b0});
        run(420);
        check_state("loss", 2'b10, 1'b0, 1'b0);
        check_events("loss");

        // Toggle resumes: re-commit 1000M
        tog_per = 4;
        ph = 0;
        exp_q.push_back({2'b10, 1'b0, 1'b1});
        run(200);
        check_state("resume", 2'b10, 1'b0, 1'b1);
        check_events("resume");

        // Lock 100M, then a single window of fast toggling must be rejected
        tog_per = 40;
        exp_q.push_back({2'b01, 1'b1, 1'b1});
        run(600);
        check_state("f_lock2", 2'b01, 1'b1, 1'b1);
        check_events("f_lock2");
        tog_per = 4;
        ph = 0;
        run(12);
        tog_per = 40;
        ph = 0;
        run(400);
        check_state("glitch", 2'b01, 1'b1, 1'b1);
        check_events("glitch");

        // Mid-window reset with toggle high; a false edge would commit one window early
        tog_per = 0;
        prescale_toggle = 1'b1;
        rst = 1'b1;
        run(1);
        check_state("rst_mid", 2'b10, 1'b0, 1'b0);
        check("rst_mid_change", 8'(speed_change), 8'h00);
        rst = 1'b0;
        run(150);
        prescale_toggle = ~prescale_toggle;
        run(150);
        check("rst_no_false_edge", 8'(speed_valid), 8'h00);
        prescale_toggle = ~prescale_toggle;
        exp_q.push_back({2'b00, 1'b1, 1'b1});
        run(100);
        check_state("rst_relock", 2'b00, 1'b1, 1'b1);
        check_events("rst_relock");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_rgmii_speed_detect.md
Name: eth_rgmii_speed_detect

Overview:
- Parametrised RGMII link-speed detector in the gtx_clk domain.
- Counts edges of an already-synchronised prescaled rx-clock toggle against a reference window and classifies the link as 10M, 100M or 1000M.
- Adds hysteresis (N agreeing windows before commit), link-loss timeout, a valid flag and a change pulse.
- Drives speed/mii_select for the RGMII PHY interface and MAC; a future RGMII MAC wrapper replaces its inline detector with this block.

Parameters:
- REF_CNT_W, 7: reference window counter width; window = 2^REF_CNT_W clk cycles.
- EDGE_CNT_W, 2: edge counter width; window also ends when the count reaches 2^EDGE_CNT_W-1.
- THRESH_100, 32: ref count at or above which an edge-saturated window votes 100M, else 1000M. Must be < 2^REF_CNT_W.
- HYST_COUNT, 2: consecutive identical votes needed to commit. Must be ≥1; 1 = immediate.
- LINK_TIMEOUT, 4: consecutive zero-edge windows that declare link down. Must be ≥2.

Ports:
- clk  in  1  gtx clock.
- rst  in  1  synchronous active-high reset.
- prescale_toggle  in  1  rx prescaler MSB, already synchronised to clk.
- speed  out  2  committed speed: 00=10M, 01=100M, 10=1000M.
- mii_select  out  1  1 when committed speed is 10M/100M.
- speed_valid  out  1  link detected and speed committed.
- speed_change  out  1  one-cycle pulse when speed or speed_valid changes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: speed=10, mii_select=0, speed_valid=0, speed_change=0. All counters, candidate and zero-window count are 0.
- During rst, toggle_q <= prescale_toggle, so there is no false edge at reset release.
- Edge detection: edge = prescale_toggle ^ toggle_q, registered every cycle.
- Each cycle ref_cnt increments. edge_cnt increments on edge.
- Window end, evaluated on registered counts with this priority:
  1. edge_cnt == all-ones: vote 1000M if ref_cnt < THRESH_100, else 100M.
  2. Otherwise ref_cnt == all-ones with edge_cnt != 0: vote 10M.
  3. Otherwise ref_cnt == all-ones with edge_cnt == 0: zero-edge window, no vote.
- At window end, ref_cnt and edge_cnt <= 0. An edge arriving on the window-end cycle is dropped.
- Any vote: zero_cnt <= 0.
  - If vote == cand, cand_cnt increments, saturating at HYST_COUNT.
  - Else cand <= vote and cand_cnt <= 1.
- Commit: when the updated cand_cnt ≥ HYST_COUNT and (vote != speed or !speed_valid):
  - speed <= vote, mii_select <= (vote != 10), speed_valid <= 1, speed_change <= 1.
  - Outputs are visible the cycle after window end.
- Zero-edge window: zero_cnt increments, saturating; candidate is untouched, so 10M gaps do not break hysteresis.
  - When zero_cnt reaches LINK_TIMEOUT while speed_valid=1: speed_valid <= 0, cand_cnt <= 0, speed_change <= 1.
  - speed and mii_select hold their last value.
- speed_change is high for exactly one cycle per change and otherwise 0.
- Re-commit of an unchanged speed while valid produces no pulse.
- A rst asserted mid-window restores all reset values on the next edge and aborts the window.

Decomposition:
- Shared eth package:
  - SPEED_10M=2'b00, SPEED_100M=2'b01, SPEED_1000M=2'b10 constants.
  - A speed typedef.
- One sub-module: eth_speed_hyst_filter. It holds cand/cand_cnt/commit logic and takes a vote valid/value and timeout-clear input. Window counting stays in the top.

Test Plan:
- 1000M (defaults): toggle every 4 clk from reset -> first window ends at ref≈12 and votes 1000M. After 2nd window: speed_valid=1, speed=10, mii_select=0, single speed_change pulse.
- 100M: toggle every 40 clk -> edge saturation at ref≈120 ≥32 votes 100M. After 2 windows: speed=01, mii_select=1, one pulse.
- 10M: toggle every 200 clk -> 128-cycle windows alternate 0/1 edges, and only 1-edge windows vote. After 2 votes: speed=00, mii_select=1, speed_valid never drops.
- Link loss: locked 1000M, toggle frozen -> after 4 consecutive zero windows (~512 clk): speed_valid=0, speed stays 10, one pulse. Toggle resumes -> re-commit after 2 windows with a pulse.
- Glitch rejection: locked 100M, one window of 4-clk toggling then back to 40-clk -> speed stays 01, no pulse.
- Reset: assert rst mid-window with prescale_toggle=1 and release -> reset values next cycle. No edge counted on the first post-reset cycle.
